// File: rtl/sirv_irq_cond.sv
// sirv_irq_cond: synchronizes device interrupt lines and conditions them as level or stretched-edge requests.
// Optional glitch filter between synchronizer and level/edge logic: define SIRV_IRQ_COND_FILTER_EN.
`default_nettype none

module sirv_irq_cond #(
  parameter int                 IRQ_NUM     = 15,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK   = '0,
  parameter int                 STRETCH_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [IRQ_NUM-1:0] irq_en_i,
  output logic [IRQ_NUM-1:0] irq_o
);

  logic [IRQ_NUM-1:0] sync_q1;
  logic [IRQ_NUM-1:0] sync_q2;
  logic [IRQ_NUM-1:0] cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_i;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SIRV_IRQ_COND_FILTER_EN
  logic [IRQ_NUM-1:0] s_d1;
  logic [IRQ_NUM-1:0] s_d2;
  logic [IRQ_NUM-1:0] filt;
  logic [IRQ_NUM-1:0] all_eq;

  // Filter output follows the synchronized line only after three agreeing samples.
  assign all_eq = ~(sync_q2 ^ s_d1) & ~(s_d1 ^ s_d2);
  assign cond   = (all_eq & sync_q2) | (~all_eq & filt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d1 <= '0;
      s_d2 <= '0;
      filt <= '0;
    end else begin
      s_d1 <= sync_q2;
      s_d2 <= s_d1;
      filt <= cond;
    end
  end
`else
  assign cond = sync_q2;
`endif

  for (genvar i = 0; i < IRQ_NUM; i++) begin : g_src
    logic out_q;
    assign irq_o[i] = out_q;

    if (EDGE_MASK[i]) begin : g_edge
      localparam int             CW     = $clog2(STRETCH_CYC + 1);
      localparam logic [CW-1:0]  RELOAD = CW'(STRETCH_CYC);

      logic          hist;
      logic          rise;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;

      // History runs even while disabled so a held-high line never looks like a fresh edge.
      assign rise = cond[i] & ~hist;

      always_comb begin
        cnt_nxt = cnt;
        if (!irq_en_i[i]) begin
          cnt_nxt = '0;
        end else if (rise) begin
          cnt_nxt = RELOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist  <= 1'b0;
          cnt   <= '0;
          out_q <= 1'b0;
        end else begin
          hist  <= cond[i];
          cnt   <= cnt_nxt;
          out_q <= (cnt_nxt != '0);
        end
      end
    end else begin : g_level
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= 1'b0;
        end else begin
          out_q <= irq_en_i[i] & cond[i];
        end
      end
    end
  end

endmodule

`default_nettype wire
